// File: rtl/mux_pam_pkg.sv
// Shared types and the round-robin pick helper for the mux_pam arbiter.
package mux_pam_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  // Largest requester count rr_pick can scan.
  localparam int unsigned RR_MAX = 32;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } rr_pick_t;

  // First requester after last_ptr, scanning upward and wrapping at depth-1.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                       input int unsigned       last_ptr,
                                       input int unsigned       depth);
    rr_pick_t    r;
    int unsigned i;
    r = '0;
    for (int unsigned k = 1; k <= RR_MAX; k++) begin
      i = (last_ptr + k) % depth;
      if (k <= depth && !r.found && req[i]) begin
        r.found = 1'b1;
        r.idx   = 5'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_pam.sv
// Depth-to-1 data select; out-of-range selects (non power-of-2 Depth) give zero.
module mux_pam #(
  parameter int Width = 64,
  parameter int Depth = 4
) (
  input  logic [Width-1:0]         INPUTS [Depth],
  input  logic [$clog2(Depth)-1:0] SEL,
  output logic [Width-1:0]         OUT
);

  always_comb begin
    OUT = '0;
    if (int'(SEL) < Depth) OUT = INPUTS[SEL];
  end

endmodule

// File: rtl/mux_pam_arbiter.sv
// Round-robin arbiter feeding one registered valid/ready output stage.
// ARB_HOLD_EN adds REQ_LAST and keeps a lane granted until its burst ends.
module mux_pam_arbiter
  import mux_pam_pkg::*;
#(
  parameter int Width = 64,
  parameter int Depth = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [Width-1:0]         INPUTS [Depth],
  input  logic [Depth-1:0]         REQ,
`ifdef ARB_HOLD_EN
  input  logic [Depth-1:0]         REQ_LAST,
`endif
  output logic [Depth-1:0]         GNT,
  output logic [Width-1:0]         OUT,
  output logic [$clog2(Depth)-1:0] OUT_SEL,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY
);

  localparam int SW = $clog2(Depth);

  logic             load;
  logic             grant;
  logic             win_vld;
  logic [SW-1:0]    win;
  rr_pick_t         pick;
  logic [Width-1:0] mux_out;

  logic [Width-1:0] out_q;
  logic [SW-1:0]    sel_q;
  logic [SW-1:0]    last_ptr_q;
  logic             vld_q;
`ifdef ARB_HOLD_EN
  arb_state_t       state_q;
  logic [SW-1:0]    lock_idx_q;
`endif

  // A new word may enter when the stage is empty or being drained this cycle.
  assign load = ~vld_q | OUT_READY;

  always_comb begin
    pick    = rr_pick(RR_MAX'(REQ), int'(last_ptr_q), Depth);
    win     = SW'(pick.idx);
    win_vld = pick.found;
`ifdef ARB_HOLD_EN
    // Locked: only the burst owner may be granted, idle cycles are not back-filled.
    if (state_q == ARB_LOCKED) begin
      win     = lock_idx_q;
      win_vld = REQ[lock_idx_q];
    end
`endif
    grant = load & win_vld;
    GNT   = '0;
    if (grant) GNT[win] = 1'b1;
  end

  mux_pam #(.Width(Width), .Depth(Depth)) u_mux (
    .INPUTS (INPUTS),
    .SEL    (win),
    .OUT    (mux_out)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_q      <= '0;
      sel_q      <= '0;
      vld_q      <= 1'b0;
      last_ptr_q <= SW'(Depth - 1);
`ifdef ARB_HOLD_EN
      state_q    <= ARB_IDLE;
      lock_idx_q <= '0;
`endif
    end else if (grant) begin
      out_q <= mux_out;
      sel_q <= win;
      vld_q <= 1'b1;
`ifdef ARB_HOLD_EN
      if (REQ_LAST[win]) begin
        last_ptr_q <= win;
        state_q    <= ARB_IDLE;
      end else begin
        lock_idx_q <= win;
        state_q    <= ARB_LOCKED;
      end
`else
      last_ptr_q <= win;
`endif
    end else if (load) begin
      vld_q <= 1'b0;
    end
  end

  assign OUT       = out_q;
  assign OUT_SEL   = sel_q;
  assign OUT_VALID = vld_q;

endmodule
